// File: rtl/riscv_dbg_pkg.sv
// Shared types and sizing helpers for the debug/readout blocks.
// The checksum state is only reached in builds with ELEMENT_DUMP_CHECKSUM_EN.
package riscv_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } dump_state_e;

  localparam int DATA_W_DEF     = 64;
  localparam int BYTES_PER_ELEM = DATA_W_DEF / 8;

  // Counter must hold the byte count itself without wrapping.
  function automatic int cnt_width(input int nbytes);
    return $clog2(nbytes + 1);
  endfunction

endpackage

// File: rtl/element_dump_tx_byte_mux_sel.sv
// Combinational byte selector: byte k of data_i is data_i[8k+7:8k].
// An out-of-range index yields 8'h00.
module byte_mux_sel #(
  parameter int NBYTES = 64,
  parameter int IDX_W  = 7
) (
  input  logic [NBYTES*8-1:0] data_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [7:0]          byte_o
);

  always_comb begin
    byte_o = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx_i == IDX_W'(k)) byte_o = data_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/element_dump_tx.sv
// Snapshots NUM_ELEM elements and streams them LSB byte first over valid/ready.
// Define ELEMENT_DUMP_CHECKSUM_EN to append one XOR checksum byte.
module element_dump_tx
  import riscv_dbg_pkg::*;
#(
  parameter int NUM_ELEM = 8,
  parameter int DATA_W   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_ELEM*DATA_W-1:0] elements_in,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int NBYTES = NUM_ELEM * DATA_W / 8;
  localparam int CNT_W  = cnt_width(NBYTES);
  localparam int SNAP_W = NUM_ELEM * DATA_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  dump_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [7:0]        data_q, data_d, sel_byte;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic              fire;
`ifdef ELEMENT_DUMP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Selector looks at next-state snapshot/counter so out_data stays registered.
  byte_mux_sel #(.NBYTES(NBYTES), .IDX_W(CNT_W)) u_sel (
    .data_i (snap_d),
    .idx_i  (cnt_d),
    .byte_o (sel_byte)
  );

  assign fire = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ELEMENT_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = elements_in;
          cnt_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SEND;
`ifdef ELEMENT_DUMP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      ST_SEND: begin
        if (fire) begin
`ifdef ELEMENT_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          if (cnt_q == LAST_IDX) begin
`ifdef ELEMENT_DUMP_CHECKSUM_EN
            cnt_d   = CNT_W'(NBYTES);
            state_d = ST_CSUM;
`else
            cnt_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef ELEMENT_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (fire) begin
          cnt_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = 8'h00;
    if (state_d == ST_SEND) data_d = sel_byte;
`ifdef ELEMENT_DUMP_CHECKSUM_EN
    else if (state_d == ST_CSUM) data_d = csum_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ELEMENT_DUMP_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ELEMENT_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_element_dump_tx.sv
// Directed bench for element_dump_tx; drives and samples on the falling edge.
// Build with ELEMENT_DUMP_CHECKSUM_EN to cover the checksum byte.
module tb_element_dump_tx;
  localparam int NE = 8;
  localparam int DW = 64;
  localparam int ND = NE * DW / 8;
`ifdef ELEMENT_DUMP_CHECKSUM_EN
  localparam int NB = ND + 1;
`else
  localparam int NB = ND;
`endif

  logic clk = 1'b0;
  logic reset, start, out_ready, out_valid, busy, done;
  logic [7:0] out_data;
  logic [NE*DW-1:0] elements_in;

  int checks = 0;
  int errors = 0;
  int dones_seen;
  logic [7:0] exp_b [NB];
  logic [7:0] obs_b [NB];
  logic [NE*DW-1:0] basic_v;

  element_dump_tx #(.NUM_ELEM(NE), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .elements_in(elements_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input logic [NE*DW-1:0] s);
`ifdef ELEMENT_DUMP_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    for (int k = 0; k < ND; k++) begin
      exp_b[k] = s[8*k +: 8];
`ifdef ELEMENT_DUMP_CHECKSUM_EN
      x = x ^ exp_b[k];
`endif
    end
`ifdef ELEMENT_DUMP_CHECKSUM_EN
    exp_b[ND] = x;
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Receive NB bytes. bp: ready pattern 1,0,0,1. poke_at: restart+new data at that
  // byte. abort_at: assert reset at that byte and stop.
  task automatic recv(input string tag, input bit bp, input int poke_at, input int abort_at);
    int k, cyc;
    bit stalled, r;
    logic [7:0] held;
    k = 0; cyc = 0; stalled = 0; held = 8'h00;
    dones_seen = 0;
    while (k < NB) begin
      if (cyc > 400) begin
        chk({tag, "_timeout"}, 8'(k), 8'(NB));
        break;
      end
      if (done) dones_seen++;
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        chk1("rst_async_valid", out_valid, 1'b0);
        chk1("rst_async_busy", busy, 1'b0);
        chk1("rst_async_done", done, 1'b0);
        break;
      end
      if (k == poke_at) begin
        start = 1'b1;
        elements_in = '1;
      end else begin
        start = 1'b0;
      end
      if (out_valid) begin
        if (stalled) chk({tag, "_hold"}, out_data, held);
        r = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
        out_ready = r;
        if (r) begin
          obs_b[k] = out_data;
          chk($sformatf("%s_b%0d", tag, k), out_data, exp_b[k]);
          k++;
          stalled = 0;
        end else begin
          held = out_data;
          stalled = 1;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic post(input string tag);
    chk1({tag, "_done"}, done, 1'b1);
    chk1({tag, "_valid_off"}, out_valid, 1'b0);
    chk1({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_early_done"}, 8'(dones_seen), 8'd0);
    @(negedge clk);
    chk1({tag, "_done_1cyc"}, done, 1'b0);
    chk1({tag, "_idle"}, out_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; out_ready = 1'b0; elements_in = '0;
    repeat (3) @(negedge clk);
    chk1("reset_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk("reset_data", out_data, 8'h00);
    reset = 1'b1;

    // Basic dump
    basic_v = '0;
    basic_v[63:0]   = 64'h0807060504030201;
    basic_v[127:64] = 64'h100F0E0D0C0B0A09;
    elements_in = basic_v;
    set_exp(basic_v);
    @(negedge clk); start = 1'b1;
    chk1("pre_start_valid", out_valid, 1'b0);
    @(negedge clk); start = 1'b0;
    chk1("first_valid", out_valid, 1'b1);
    chk1("first_busy", busy, 1'b1);
    recv("basic", 1'b0, -1, -1);
    chk("basic_hand0", obs_b[0], 8'h01);
    chk("basic_hand15", obs_b[15], 8'h10);
    chk("basic_hand16", obs_b[16], 8'h00);
    chk("basic_hand63", obs_b[63], 8'h00);
    post("basic");

    // Backpressure
    pulse_start();
    recv("bp", 1'b1, -1, -1);
    chk("bp_hand8", obs_b[8], 8'h09);
    post("bp");

    // Snapshot isolation + start while busy
    pulse_start();
    recv("iso", 1'b0, 10, -1);
    chk("iso_hand12", obs_b[12], 8'h0D);
    post("iso");
    elements_in = basic_v;

    // Reset mid-transfer, then restart
    pulse_start();
    recv("rst", 1'b0, -1, 20);
    @(negedge clk);
    reset = 1'b1;
    chk1("rst_no_done", done, 1'b0);
    chk1("rst_idle", out_valid, 1'b0);
    pulse_start();
    recv("rst2", 1'b0, -1, -1);
    chk("rst2_hand0", obs_b[0], 8'h01);
    post("rst2");

`ifdef ELEMENT_DUMP_CHECKSUM_EN
    elements_in = '0;
    elements_in[63:0] = 64'h0807060504030201;
    set_exp(elements_in);
    pulse_start();
    recv("cs", 1'b1, -1, -1);
    chk("cs_hand", obs_b[64], 8'h08);
    post("cs");
    elements_in = basic_v;
    set_exp(basic_v);
`endif

    // Back-to-back start in the done cycle
    pulse_start();
    recv("b2b1", 1'b0, -1, -1);
    chk1("b2b1_done", done, 1'b1);
    elements_in = {NE{64'hA5A5_A5A5_A5A5_A5A5}};
    set_exp(elements_in);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk1("b2b_no_gap", out_valid, 1'b1);
    recv("b2b2", 1'b0, -1, -1);
    chk("b2b2_hand0", obs_b[0], 8'hA5);
    chk("b2b2_hand63", obs_b[63], 8'hA5);
    post("b2b2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
